gpio_pad_ctrl: RTL and testbench

- Core-side controller for a bank of N bidirectional GPIO pad buffers.
- Drives each pad buffer's dout, oen and ie through registers, so the pad sees no combinational glitches from the core.
- Returns pad data to the core through a synchronizer, a per-bit debounce filter and edge detection.
- Keeps a sticky, maskable interrupt status per bit.
- Sits between the core register file and the pad ring.

---
 rtl/gpio_pad_ctrl.sv | 138 +++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_ctrl
// Description : Core-side controller for a bank of N bidirectional GPIO pads.
//               Registers dout/oen/ie towards the pad ring, and returns pad
//               data through a synchronizer, a per-bit debounce filter and
//               edge detection. Keeps a sticky, maskable interrupt status per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pad_ctrl #(
  parameter int N          = 8,
  parameter int SYNCSTAGES = 2,   // must be 2 or more
  parameter int DBW        = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   out_val,
  input  logic [N-1:0]   oe,
  input  logic [N-1:0]   ie_cfg,
  input  logic [DBW-1:0] db_limit,
  input  logic [N-1:0]   rise_en,
  input  logic [N-1:0]   fall_en,
  input  logic [N-1:0]   irq_clear,
  output logic [N-1:0]   dout,
  output logic [N-1:0]   oen,
  output logic [N-1:0]   ie,
  input  logic [N-1:0]   din,
  output logic [N-1:0]   in_val,
  output logic [N-1:0]   rise,
  output logic [N-1:0]   fall,
  output logic [N-1:0]   irq_status,
  output logic           irq
);

  localparam logic [DBW-1:0] c_CNT_ONE = {{(DBW-1){1'b0}}, 1'b1};

  logic [N-1:0] r_dout;
  logic [N-1:0] r_oen;
  logic [N-1:0] r_ie;
  logic [N-1:0] r_irq_status;
  logic [N-1:0] w_in_val;
  logic [N-1:0] w_rise;
  logic [N-1:0] w_fall;
  logic [N-1:0] w_set;

  // Pad-side controls are registered so the pad ring never sees core glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
      r_oen  <= '1;
      r_ie   <= '0;
    end else begin
      r_dout <= out_val;
      r_oen  <= ~oe;
      r_ie   <= ie_cfg;
    end
  end

  assign dout = r_dout;
  assign oen  = r_oen;
  assign ie   = r_ie;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic [SYNCSTAGES-1:0] r_sync;
    logic [DBW-1:0]        r_cnt;
    logic                  r_val;
    logic                  r_rise;
    logic                  r_fall;
    logic                  w_s;

    assign w_s = r_sync[SYNCSTAGES-1];

    // Synchronizer chain; held clear while the input buffer is disabled.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync <= '0;
      end else if (!r_ie[gi]) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNCSTAGES-2:0], din[gi]};
      end
    end

    // Debounce: accept a new level only after it has been stable past db_limit;
    // >= lets a lowered db_limit take effect on a counter already beyond it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt  <= '0;
        r_val  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else if (!r_ie[gi]) begin
        // Disabled input reads as 0 without producing an edge.
        r_cnt  <= '0;
        r_val  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (w_s == r_val) begin
          r_cnt <= '0;
        end else if (r_cnt >= db_limit) begin
          r_val  <= w_s;
          r_cnt  <= '0;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end

    assign w_in_val[gi] = r_val;
    assign w_rise[gi]   = r_rise;
    assign w_fall[gi]   = r_fall;
  end

  assign in_val = w_in_val;
  assign rise   = w_rise;
  assign fall   = w_fall;

  assign w_set = (w_rise & rise_en) | (w_fall & fall_en);

  // Sticky status: a new event wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_status <= '0;
    end else begin
      r_irq_status <= (r_irq_status & ~irq_clear) | w_set;
    end
  end

  assign irq_status = r_irq_status;
  assign irq        = |r_irq_status;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_pad_ctrl
// Description : Directed self-checking bench for gpio_pad_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gpio_pad_ctrl;
  localparam int N          = 8;
  localparam int SYNCSTAGES = 2;
  localparam int DBW        = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   out_val, oe, ie_cfg, rise_en, fall_en, irq_clear;
  logic [DBW-1:0] db_limit;
  logic [N-1:0]   pad;
  logic [N-1:0]   din;
  logic [N-1:0]   dout, oen, ie, in_val, rise, fall, irq_status;
  logic           irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Pad buffer model: returns 0 while its input enable is low.
  assign din = pad & ie;

  gpio_pad_ctrl #(.N(N), .SYNCSTAGES(SYNCSTAGES), .DBW(DBW)) u_dut (
    .clk(clk), .reset(reset), .out_val(out_val), .oe(oe), .ie_cfg(ie_cfg),
    .db_limit(db_limit), .rise_en(rise_en), .fall_en(fall_en),
    .irq_clear(irq_clear), .dout(dout), .oen(oen), .ie(ie), .din(din),
    .in_val(in_val), .rise(rise), .fall(fall), .irq_status(irq_status),
    .irq(irq)
  );

  task automatic t_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a rise/fall pulse on bit 0; returns at the pulse cycle.
  task automatic wait_pulse(input string tag, input bit want_rise);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 30) begin
      tick;
      n++;
      seen = want_rise ? rise[0] : fall[0];
    end
    t_check(tag, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    bit seen_r, seen_f;
    reset = 1'b1; out_val = '0; oe = '0; ie_cfg = '0; rise_en = '0;
    fall_en = '0; irq_clear = '0; db_limit = '0; pad = '0;

    // 1. Reset values, then idle
    #2;
    t_check("rst_oen",    oen,    32'hFF);
    t_check("rst_dout",   dout,   32'h00);
    t_check("rst_ie",     ie,     32'h00);
    t_check("rst_in_val", in_val, 32'h00);
    t_check("rst_irq",    irq,    32'h0);
    tick; tick;
    reset = 1'b0;
    tick; tick; tick;
    t_check("idle_oen",  oen,        32'hFF);
    t_check("idle_in",   in_val,     32'h00);
    t_check("idle_rise", rise,       32'h00);
    t_check("idle_stat", irq_status, 32'h00);

    // 2. Drive path
    oe = 8'h01; out_val = 8'h01;
    tick;
    t_check("drv_dout1", dout, 32'h01);
    t_check("drv_oen",   oen,  32'hFE);
    out_val = 8'h00;
    tick;
    t_check("drv_dout0", dout, 32'h00);
    out_val = 8'h01;
    tick;
    t_check("drv_dout2", dout, 32'h01);
    t_check("drv_oen2",  oen,  32'hFE);

    // 3. Clean rising edge, db_limit=3: in_val at k+5
    db_limit = 8'd3; ie_cfg = 8'h01;
    tick; tick; tick;
    t_check("ie_on", ie, 32'h01);
    pad = 8'h01;
    tick;                                   // edge k
    for (int i = 1; i <= 6; i++) begin
      tick;
      t_check($sformatf("edge_in_%0d", i),   in_val[0], (i >= 5) ? 32'd1 : 32'd0);
      t_check($sformatf("edge_rise_%0d", i), rise[0],   (i == 5) ? 32'd1 : 32'd0);
      t_check($sformatf("edge_fall_%0d", i), fall[0],   32'd0);
    end
    t_check("edge_stat", irq_status, 32'h00);

    // 4. Glitch rejection
    pad = 8'h00;
    wait_pulse("g_fall_wait", 1'b0);
    tick;
    t_check("g_low", in_val[0], 32'd0);
    seen_r = 1'b0;
    for (int i = 0; i < 14; i++) begin
      pad = (i < 3) ? 8'h01 : 8'h00;
      tick;
      seen_r |= rise[0];
    end
    t_check("g3_rise", {31'b0, seen_r}, 32'd0);
    t_check("g3_in",   in_val[0],       32'd0);
    seen_r = 1'b0; seen_f = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pad = (i < 4) ? 8'h01 : 8'h00;
      tick;
      seen_r |= rise[0];
      seen_f |= fall[0];
    end
    t_check("g4_rise", {31'b0, seen_r}, 32'd1);
    t_check("g4_fall", {31'b0, seen_f}, 32'd1);
    t_check("g4_in",   in_val[0],       32'd0);

    // 5. Interrupts
    rise_en = 8'h01;
    pad = 8'h01;
    wait_pulse("i_rise1", 1'b1);
    tick;
    t_check("i_stat1", irq_status, 32'h01);
    t_check("i_irq1",  irq,        32'h1);
    pad = 8'h00;
    wait_pulse("i_fall", 1'b0);
    tick;
    t_check("i_stat_fall", irq_status, 32'h01);
    pad = 8'h01;
    wait_pulse("i_rise2", 1'b1);
    irq_clear = 8'h01;
    tick;
    t_check("i_setwins", irq_status, 32'h01);
    tick;
    t_check("i_clear",   irq_status, 32'h00);
    t_check("i_irq0",    irq,        32'h0);
    irq_clear = 8'h00;

    // 6. Input disable and re-enable (pad held high)
    fall_en = 8'h01;
    ie_cfg  = 8'h00;
    tick;
    t_check("dis_ie",  ie,        32'h00);
    t_check("dis_in1", in_val[0], 32'd1);
    tick;
    t_check("dis_in0",  in_val[0], 32'd0);
    t_check("dis_fall", fall[0],   32'd0);
    tick;
    t_check("dis_stat", irq_status, 32'h00);
    ie_cfg = 8'h01;
    for (int i = 1; i <= 8; i++) begin
      tick;
      t_check($sformatf("ren_rise_%0d", i), rise[0],   (i == 7) ? 32'd1 : 32'd0);
      t_check($sformatf("ren_in_%0d", i),   in_val[0], (i >= 7) ? 32'd1 : 32'd0);
    end
    irq_clear = 8'h01;
    tick;
    irq_clear = 8'h00;
    t_check("ren_clr", irq_status, 32'h00);

    // db_limit=0: no filtering, in_val follows 2 edges after capture
    db_limit = 8'd0;
    pad = 8'h00;
    for (int i = 1; i <= 4; i++) begin
      tick;
      t_check($sformatf("nf_in_%0d", i),   in_val[0], (i < 3) ? 32'd1 : 32'd0);
      t_check($sformatf("nf_fall_%0d", i), fall[0],   (i == 3) ? 32'd1 : 32'd0);
    end
    t_check("nf_stat", irq_status, 32'h01);

    // Asynchronous reset mid-cycle, then resume without spurious edges
    #3 reset = 1'b1;
    #1;
    t_check("arst_oen",  oen,        32'hFF);
    t_check("arst_dout", dout,       32'h00);
    t_check("arst_stat", irq_status, 32'h00);
    t_check("arst_irq",  irq,        32'h0);
    tick;
    reset = 1'b0;
    seen_r = 1'b0; seen_f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      seen_r |= rise[0];
      seen_f |= fall[0];
    end
    t_check("post_rise", {31'b0, seen_r}, 32'd0);
    t_check("post_fall", {31'b0, seen_f}, 32'd0);
    t_check("post_oen",  oen,             32'hFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
